gpio_led_ctrl: RTL and testbench
================================

Name: gpio_led_ctrl

Overview:
Parametrised multi-channel LED controller driven from the EMPU GPIO word, replacing direct GPIO-bit-to-LED wiring. Each channel is independently configured through a strobed write port with one of four modes: OFF, ON, BLINK or PWM. A shared prescaler and a PWM counter provide the timing. It sits in the FPGA top level between the Gowin EMPU GPIO outputs and the board LED pins.

Parameters:
NUM_LED, 2, number of LED channels (1..16)
CH_W, 4, width of channel index; requires 2**CH_W >= NUM_LED
TICK_DIV, 270000, sys_clk_i cycles per blink tick (10 ms at 27 MHz); must be >= 2
PWM_DIV, 4, sys_clk_i cycles per PWM counter step; must be >= 1
ACTIVE_LOW, 0, 1 = LED pin lit when driven low

Ports:
sys_clk_i  in  1  system clock; single clock domain
sys_rst_i  in  1  asynchronous, active-high reset
cfg_stb_i  in  1  write strobe, level from GPIO; acted on at rising edge only
cfg_ch_i  in  CH_W  target channel
cfg_mode_i  in  2  0=OFF 1=ON 2=BLINK 3=PWM
cfg_val_i  in  8  BLINK: half-period in ticks; PWM: duty/256
cfg_ack_o  out  1  one-cycle pulse: write accepted
cfg_err_o  out  1  one-cycle pulse: write rejected (cfg_ch_i >= NUM_LED)
led_o  out  NUM_LED  LED pins, registered

Behaviour:
- Reset (async assert, sync release): mode=OFF and val=0 on all channels; prescaler, PWM counter, blink counters and phases are 0; stb_prev=0; cfg_ack_o=0, cfg_err_o=0; led_o = all 1s if ACTIVE_LOW else all 0s. A reset during a write discards the write.
- Strobe edge: wr = cfg_stb_i & ~stb_prev, where stb_prev is cfg_stb_i registered. A held-high strobe produces exactly one write. Level toggles at 1 cycle per level must each be caught.
- Write at cycle N (wr=1):
  - Valid channel: mode/val registered at the end of N, cfg_ack_o=1 in cycle N+1, led_o reflects the new config from cycle N+2.
  - Invalid channel: nothing changes and cfg_err_o=1 in cycle N+1.
  - The written channel's blink counter is cleared and its phase set to 1 (lit), so BLINK always starts lit.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 on the wrap cycle. It is shared and never cleared by writes.
- PWM counter: 8-bit, increments once per PWM_DIV clocks and wraps 255->0.
- Per-channel raw state, before the output register:
  - OFF: 0.
  - ON: 1.
  - BLINK: on each tick, bcnt+1 is compared to hp, where hp = val, or 1 if val==0. If bcnt+1 == hp, phase toggles and bcnt clears; otherwise bcnt increments. raw = phase.
  - PWM: raw = (pwm_cnt < val). val=0 is always off; val=255 is lit 255/256.
- A counter (bcnt) in a non-BLINK mode holds its value; it is reset by the next write.
- Output: led_o[i] = raw ^ ACTIVE_LOW, registered once.
- The write port and timers are independent; a write on a tick cycle takes the write's counter clear (the write has priority over the tick).
- Arithmetic: the prescaler counter is $clog2(TICK_DIV) bits and bcnt is 8 bits; all compares are unsigned.

Decomposition:
- Package gpio_led_pkg holds:
  - mode localparams MODE_OFF/ON/BLINK/PWM;
  - mode width 2;
  - value width 8.
- Sub-module gpio_led_chan is instantiated NUM_LED times via generate. It holds one channel's mode/val registers, bcnt/phase, raw output logic and output flop. Its inputs are the write-enable decode, tick and pwm_cnt.
- The prescaler, PWM counter, strobe edge detector and ack/err logic stay in the top-level gpio_led_ctrl.

Test Plan:
All scenarios use TICK_DIV=4, PWM_DIV=1, NUM_LED=2, ACTIVE_LOW=0.
1. Reset, then idle 100 cycles -> led_o=2'b00, no ack/err. Assert sys_rst_i mid-run -> led_o=00 immediately (async).
2. Strobe write ch0 mode=ON held high 10 cycles -> exactly one cfg_ack_o pulse at N+1, led_o[0]=1 from N+2, led_o[1] stays 0.
3. Write ch1 BLINK val=2 -> led_o[1] lit, then toggles every 8 cycles (2 ticks x 4); val=0 toggles every 4 cycles.
4. Write ch0 PWM val=64 -> over 256 cycles, led_o[0] high exactly 64 cycles; val=0 -> never high; val=255 -> high 255 of 256.
5. Write cfg_ch_i=3 -> cfg_err_o pulse at N+1, no ack, led_o unchanged.
6. Rerun scenario 3 with ACTIVE_LOW=1 -> led_o inverted, reset value 2'b11.

Source files
------------

// File: rtl/gpio_led_pkg.sv
// Shared mode encodings and field widths for the GPIO LED controller.
package gpio_led_pkg;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned VAL_W  = 8;

   localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
   localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
   localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
   localparam logic [MODE_W-1:0] MODE_PWM   = 2'd3;

endpackage

// File: rtl/gpio_led_chan.sv
// One LED channel: config registers, blink timer, raw level and output flop.
module gpio_led_chan
   import gpio_led_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [MODE_W-1:0] wr_mode,
   input  logic [VAL_W-1:0]  wr_val,
   input  logic              tick,
   input  logic [VAL_W-1:0]  pwm_cnt,
   output logic              led
);

   logic [MODE_W-1:0] mode;
   logic [VAL_W-1:0]  val;
   logic [VAL_W-1:0]  bcnt;
   logic              phase;
   logic [VAL_W-1:0]  hp_c;
   logic [VAL_W-1:0]  bcnt_inc_c;
   logic              raw_c;

   // Blink half-period (zero treated as one tick) and next counter value
   always_comb begin
      hp_c       = (val == '0) ? VAL_W'(1) : val;
      bcnt_inc_c = bcnt + VAL_W'(1);
   end

   // Channel configuration, loaded on an accepted write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode <= MODE_OFF;
         val  <= '0;
      end else if (we) begin
         mode <= wr_mode;
         val  <= wr_val;
      end
   end

   // Blink timer; a write restarts it lit and wins over a coincident tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (we) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (tick && (mode == MODE_BLINK)) begin
         if (bcnt_inc_c == hp_c) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt_inc_c;
         end
      end
   end

   // Unregistered lit/unlit level for the current mode
   always_comb begin
      raw_c = 1'b0;
      case (mode)
         MODE_ON:    raw_c = 1'b1;
         MODE_BLINK: raw_c = phase;
         MODE_PWM:   raw_c = (pwm_cnt < val);
         default:    raw_c = 1'b0;
      endcase
   end

   // Output pin register with polarity applied
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led <= ACTIVE_LOW;
      end else begin
         led <= raw_c ^ ACTIVE_LOW;
      end
   end

endmodule

// File: rtl/gpio_led_ctrl.sv
// Multi-channel LED controller: strobed config port, shared tick and PWM timers.
module gpio_led_ctrl
   import gpio_led_pkg::*;
#(
   parameter int unsigned NUM_LED    = 2,
   parameter int unsigned CH_W       = 4,
   parameter int unsigned TICK_DIV   = 270000,
   parameter int unsigned PWM_DIV    = 4,
   parameter int unsigned ACTIVE_LOW = 0
) (
   input  logic               sys_clk_i,
   input  logic               sys_rst_i,
   input  logic               cfg_stb_i,
   input  logic [CH_W-1:0]    cfg_ch_i,
   input  logic [MODE_W-1:0]  cfg_mode_i,
   input  logic [VAL_W-1:0]   cfg_val_i,
   output logic               cfg_ack_o,
   output logic               cfg_err_o,
   output logic [NUM_LED-1:0] led_o
);

   localparam int unsigned PRE_W  = $clog2(TICK_DIV);
   localparam int unsigned PDIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

   logic [PRE_W-1:0]   pre_cnt;
   logic [PDIV_W-1:0]  pdiv_cnt;
   logic [VAL_W-1:0]   pwm_cnt;
   logic               stb_prev;
   logic               tick_c;
   logic               pwm_step_c;
   logic               wr_c;
   logic               ch_ok_c;
   logic [NUM_LED-1:0] we_c;

   // Strobe rising edge, channel range check and timer wrap decodes
   always_comb begin
      wr_c       = cfg_stb_i & ~stb_prev;
      ch_ok_c    = (32'(cfg_ch_i) < NUM_LED);
      tick_c     = (pre_cnt == PRE_W'(TICK_DIV - 1));
      pwm_step_c = (pdiv_cnt == PDIV_W'(PWM_DIV - 1));
   end

   // Strobe history for edge detection
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         stb_prev <= 1'b0;
      end else begin
         stb_prev <= cfg_stb_i;
      end
   end

   // Write accept/reject pulses, one cycle after the strobe edge
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         cfg_ack_o <= 1'b0;
         cfg_err_o <= 1'b0;
      end else begin
         cfg_ack_o <= wr_c & ch_ok_c;
         cfg_err_o <= wr_c & ~ch_ok_c;
      end
   end

   // Free-running blink-tick prescaler, unaffected by writes
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         pre_cnt <= '0;
      end else if (tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // PWM divider and 8-bit wrapping PWM counter
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         pdiv_cnt <= '0;
         pwm_cnt  <= '0;
      end else if (pwm_step_c) begin
         pdiv_cnt <= '0;
         pwm_cnt  <= pwm_cnt + VAL_W'(1);
      end else begin
         pdiv_cnt <= pdiv_cnt + PDIV_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
      assign we_c[i] = wr_c & ch_ok_c & (cfg_ch_i == CH_W'(i));

      gpio_led_chan #(
         .ACTIVE_LOW (ACTIVE_LOW != 0)
      ) u_chan (
         .clk     (sys_clk_i),
         .rst     (sys_rst_i),
         .we      (we_c[i]),
         .wr_mode (cfg_mode_i),
         .wr_val  (cfg_val_i),
         .tick    (tick_c),
         .pwm_cnt (pwm_cnt),
         .led     (led_o[i])
      );
   end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Self-checking bench: two controllers (active-high and active-low) on shared stimulus.
module tb_gpio_led_ctrl;

   localparam int unsigned NL = 2;
   localparam int unsigned CW = 4;
   localparam int unsigned TD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stb = 1'b0;
   logic [CW-1:0] ch = '0;
   logic [1:0]    mode = '0;
   logic [7:0]    val = '0;
   logic          ack_a, err_a, ack_b, err_b;
   logic [NL-1:0] led_a, led_b;

   always #5 clk = ~clk;

   gpio_led_ctrl #(.NUM_LED(NL), .CH_W(CW), .TICK_DIV(TD), .PWM_DIV(1), .ACTIVE_LOW(0)) u_dut_hi (
      .sys_clk_i(clk), .sys_rst_i(rst), .cfg_stb_i(stb), .cfg_ch_i(ch),
      .cfg_mode_i(mode), .cfg_val_i(val), .cfg_ack_o(ack_a), .cfg_err_o(err_a), .led_o(led_a));

   gpio_led_ctrl #(.NUM_LED(NL), .CH_W(CW), .TICK_DIV(TD), .PWM_DIV(1), .ACTIVE_LOW(1)) u_dut_lo (
      .sys_clk_i(clk), .sys_rst_i(rst), .cfg_stb_i(stb), .cfg_ch_i(ch),
      .cfg_mode_i(mode), .cfg_val_i(val), .cfg_ack_o(ack_b), .cfg_err_o(err_b), .led_o(led_b));

   // Model: config per channel with the edge index at which it took effect
   typedef struct {
      int m;
      int v;
      int w;
   } cfg_t;

   cfg_t cur[NL];
   cfg_t prv[NL];
   int   ecount;
   int   ack_edge;
   int   err_edge;
   int   n_tests = 0;
   int   n_fail = 0;

   // Ideal lit level in the state after edge e, from elapsed ticks / PWM phase
   function automatic logic raw_of(cfg_t c, int e);
      int hp;
      int k;
      case (c.m)
         1: return 1'b1;
         2: begin
            hp = (c.v == 0) ? 1 : c.v;
            k  = e / int'(TD) - c.w / int'(TD);
            return ((k / hp) % 2) == 0;
         end
         3: return (e % 256) < c.v;
         default: return 1'b0;
      endcase
   endfunction

   // Expected active-high pins after edge e (registered one edge after raw)
   function automatic logic [NL-1:0] exp_led(int e);
      logic [NL-1:0] r;
      r = '0;
      if (e > 0) begin
         for (int i = 0; i < int'(NL); i++) begin
            if (e - 1 < cur[i].w) r[i] = raw_of(prv[i], e - 1);
            else                  r[i] = raw_of(cur[i], e - 1);
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, ecount);
      end
   endtask

   // Advance one clock and compare everything against the model
   task automatic step();
      logic [NL-1:0] el;
      logic [NL-1:0] eln;
      @(posedge clk);
      ecount++;
      @(negedge clk);
      el  = exp_led(ecount);
      eln = ~el;
      check("led_hi", 32'(led_a), 32'(el));
      check("led_lo", 32'(led_b), 32'(eln));
      check("ack", 32'({ack_a, ack_b}), (ecount == ack_edge) ? 32'd3 : 32'd0);
      check("err", 32'({err_a, err_b}), (ecount == err_edge) ? 32'd3 : 32'd0);
   endtask

   // Async reset from a negedge; drops any pending strobe
   task automatic do_reset();
      #2;
      rst = 1'b1;
      stb = 1'b0;
      #1;
      check("rst_led_hi", 32'(led_a), 32'd0);
      check("rst_led_lo", 32'(led_b), 32'd3);
      check("rst_ackerr", 32'({ack_a, err_a, ack_b, err_b}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ecount   = 0;
      ack_edge = -1;
      err_edge = -1;
      for (int i = 0; i < int'(NL); i++) begin
         cur[i] = '{0, 0, 0};
         prv[i] = '{0, 0, 0};
      end
   endtask

   // Strobe held for 'hold' cycles then low for 'gap' cycles
   task automatic write(input int c, input int m, input int v, input int hold, input int gap);
      int w;
      ch   = CW'(c);
      mode = 2'(m);
      val  = 8'(v);
      stb  = 1'b1;
      w    = ecount + 1;
      if (c < int'(NL)) begin
         prv[c]   = cur[c];
         cur[c]   = '{m, v, w};
         ack_edge = w;
      end else begin
         err_edge = w;
      end
      step();
      ch   = CW'($urandom);
      mode = 2'($urandom);
      val  = 8'($urandom);
      repeat (hold - 1) step();
      stb = 1'b0;
      repeat (gap) step();
   endtask

   task automatic pwm_count(input int v);
      int cnt;
      write(0, 3, v, 1, 2);
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         cnt += int'(led_a[0]);
      end
      check("pwm_highs", 32'(cnt), 32'(v));
   endtask

   initial begin
      int c, m, v;
      @(negedge clk);
      do_reset();
      repeat (100) step();

      // Held strobe: single write
      write(0, 1, 0, 10, 5);
      // Blink half-period 2 ticks, then 0 (one tick)
      write(1, 2, 2, 1, 40);
      write(1, 2, 0, 1, 20);
      // PWM duty boundaries
      pwm_count(64);
      pwm_count(0);
      pwm_count(255);
      // Out-of-range channels
      write(3, 1, 0, 1, 5);
      write(15, 1, 0, 3, 5);
      // One-cycle strobe toggles, each a separate write
      write(0, 0, 0, 1, 1);
      write(1, 1, 0, 1, 1);
      write(0, 3, 128, 1, 1);
      write(1, 2, 1, 1, 12);
      // Reset while a write strobe is rising
      ch = '0; mode = 2'd1; val = '0; stb = 1'b1;
      do_reset();
      repeat (10) step();

      for (int n = 0; n < 40; n++) begin
         c = int'($urandom_range(0, 3));
         m = int'($urandom_range(0, 3));
         v = (m == 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
         write(c, m, v, int'($urandom_range(1, 4)), int'($urandom_range(1, 30)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
